fetch_queue: RTL and testbench

Instruction fetch stage sitting directly upstream of `imem`: owns the fetch PC, drives `imem` address, and buffers fetched words with their PCs in a small FIFO. It presents them to decode over a valid/ready handshake. Branch/jump redirects flush the queue and restart fetch at the new PC, so decode stalls never stall the PC logic incoherently.

---
 rtl/cpu_defs.sv | 7 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/fetch_queue.sv | 55 +++++
 tb/tb_fetch_queue.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU-wide constants used by the fetch path and its benches.
package cpu_defs;
  localparam int WORD_W = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; shared by the fetch queue and the store buffer.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the fetch PC, addresses imem and queues {pc, instr} for decode.
module fetch_queue
  import cpu_defs::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int                DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [0:31] imem_addr,
  input  logic [0:31] imem_instr,
  input  logic        redirect,
  input  logic [0:31] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:31] out_instr,
  output logic [0:31] out_pc
);
  logic [0:31]                fetch_pc;
  logic                       push;
  logic                       pop;
  logic                       full;
  logic                       empty;
  logic [$clog2(DEPTH):0]     count;
  logic [2*WORD_W-1:0]        head;

  assign imem_addr = fetch_pc;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // Redirect wins: nothing fetched at the stale PC may enter the queue.
  assign push      = ~redirect & (~full | pop);
  assign {out_pc, out_instr} = empty ? '0 : head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         fetch_pc <= RESET_PC;
    else if (redirect) fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
    else if (push)     fetch_pc <= fetch_pc + WORD_W'(INSTR_BYTES);
  end

  sync_fifo #(
    .WIDTH (2*WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({fetch_pc, imem_instr}),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: queue-level reference model, decoupled output monitor.
module tb_fetch_queue;
  import cpu_defs::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr, imem_instr, out_instr, out_pc;
  logic        out_valid;

  int checks = 0;
  int failures = 0;

  logic [63:0] mq[$];   // words the reference fetch buffer holds
  logic [63:0] sb[$];   // words decode is expected to accept, in order
  logic [31:0] mpc = RPC;
  bit          exp_valid = 1'b0;
  logic [31:0] exp_addr = RPC;
  bit          in_reset = 1'b1;

  always #5 clk = ~clk;

  fetch_queue #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h1111_1111;
    if (a == 32'h4) return 32'h2222_2222;
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  always_comb imem_instr = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs and advance the reference model across the coming edge.
  task automatic drive(input bit rdy, input bit redir, input logic [31:0] rpc);
    out_ready   = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    exp_valid   = (mq.size() != 0);
    exp_addr    = mpc;
    if (exp_valid && rdy) sb.push_back(mq.pop_front());
    if (redir) begin
      mq.delete();
      mpc = {rpc[31:2], 2'b00};
    end else if (mq.size() < DEPTH) begin
      mq.push_back({mpc, mem_word(mpc)});
      mpc = mpc + 32'd4;
    end
  endtask

  task automatic cycle(input bit rdy, input bit redir, input logic [31:0] rpc);
    @(negedge clk);
    #1;
    drive(rdy, redir, rpc);
  endtask

  task automatic release_reset(input bit rdy);
    @(negedge clk);
    #1;
    reset    = 1'b0;
    in_reset = 1'b0;
    mq.delete();
    sb.delete();
    mpc = RPC;
    drive(rdy, 1'b0, 32'h0);
  endtask

  // Called just after a drive; asserts reset between clock edges.
  task automatic async_reset(input bit rdy);
    #1;
    reset    = 1'b1;
    in_reset = 1'b1;
    #1;
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_imem_addr", imem_addr, RPC);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    mq.delete();
    sb.delete();
    mpc = RPC;
    repeat (2) @(posedge clk);
    release_reset(rdy);
  endtask

  // Monitor: just before each active edge, compare what decode would accept.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (!in_reset) begin
        check("out_valid", {31'h0, out_valid}, {31'h0, exp_valid});
        check("imem_addr", imem_addr, exp_addr);
        if (!out_valid) begin
          check("empty_pc", out_pc, 32'h0);
          check("empty_instr", out_instr, 32'h0);
        end else if (out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow: got pc %h expected no handshake", out_pc);
          end else begin
            e = sb.pop_front();
            check("head_pc", out_pc, e[63:32]);
            check("head_instr", out_instr, e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    bit          rdy, redir;
    logic [31:0] rpc;

    #3;
    check("por_out_valid", {31'h0, out_valid}, 32'h0);
    check("por_imem_addr", imem_addr, RPC);

    // Stream from reset with decode always ready.
    release_reset(1'b1);
    cycle(1'b1, 1'b0, 32'h0);
    check("first_valid", {31'h0, out_valid}, 32'h1);
    check("first_pc", out_pc, 32'h0);
    check("first_instr", out_instr, 32'h1111_1111);
    cycle(1'b1, 1'b0, 32'h0);
    check("second_pc", out_pc, 32'h4);
    check("second_instr", out_instr, 32'h2222_2222);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);

    // Decode stalled: queue fills and the PC holds.
    async_reset(1'b0);
    repeat (9) cycle(1'b0, 1'b0, 32'h0);
    check("fill_addr", imem_addr, 32'h10);
    check("fill_head", out_pc, 32'h0);
    repeat (8) cycle(1'b1, 1'b0, 32'h0);
    check("full_flow_addr", imem_addr, 32'h2C);
    check("full_flow_head", out_pc, 32'h1C);

    // Redirect with three entries queued.
    async_reset(1'b0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h0000_0103);
    cycle(1'b0, 1'b0, 32'h0);
    check("redir_valid", {31'h0, out_valid}, 32'h0);
    check("redir_addr", imem_addr, 32'h100);
    cycle(1'b1, 1'b0, 32'h0);
    check("redir_head", out_pc, 32'h100);

    // Redirect near the top of the address space: PC wraps.
    cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
    cycle(1'b1, 1'b0, 32'h0);
    check("wrap_addr", imem_addr, 32'hFFFF_FFF8);
    cycle(1'b1, 1'b0, 32'h0);
    check("wrap_pc0", out_pc, 32'hFFFF_FFF8);
    cycle(1'b1, 1'b0, 32'h0);
    check("wrap_pc1", out_pc, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 32'h0);
    check("wrap_pc2", out_pc, 32'h0000_0000);

    // Asynchronous reset in the middle of a drain.
    repeat (5) cycle(1'b1, 1'b0, 32'h0);
    async_reset(1'b1);
    cycle(1'b1, 1'b0, 32'h0);
    check("restart_pc", out_pc, RPC);

    // Randomised traffic.
    for (int i = 0; i < 450; i++) begin
      rdy   = ($urandom_range(0, 9) < 7);
      redir = ($urandom_range(0, 19) == 0);
      rpc   = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      cycle(rdy, redir, rpc);
      if (i % 150 == 149) async_reset(1'b1);
    end

    cycle(1'b0, 1'b0, 32'h0);
    #3;
    check("sb_drained", sb.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
